// File: rtl/imem_load_ctrl_if.sv
// Instruction-memory write bus driven by the serial loader.
// The master side presents address, data and a one-cycle write strobe.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 40
);
  logic [ADDR_W-1:0] imem_write_adr;
  logic [DATA_W-1:0] imem_in;
  logic              imem_write;

  modport master (output imem_write_adr, output imem_in, output imem_write);
  modport slave  (input  imem_write_adr, input  imem_in, input  imem_write);
endinterface

// File: rtl/imem_load_ctrl.sv
// Framed serial loader for the core instruction memory: synchronises the pad
// byte strobe and mode pins, assembles checked frames, and owns core hold / pad enables.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic [1:0]          modesel,
  input  logic [7:0]          byte_in,
  imem_load_ctrl_if.master    imem,
  output logic                core_hold,
  output logic                io_a_input_enable,
  output logic                io_a_output_enable,
  output logic                io_b_input_enable,
  output logic                io_b_output_enable,
  output logic                frame_error,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned NBYTES  = (FRAME_W + 7) / 8;
  localparam int unsigned SHIFT_W = 56;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned WC_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [WC_W-1:0]  WC_MAX    = WC_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [SYNC_STAGES-1:0]        sclk_sync_q, sclk_sync_d;
  logic                          sclk_prev_q, sclk_prev_d;
  logic [SYNC_STAGES-1:0][1:0]   mode_sync_q, mode_sync_d;
  logic [CNT_W-1:0]              byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0]            frame_q, frame_d;
  logic                          done_q, done_d;
  logic                          wr_pend_q, wr_pend_d;
  logic                          imem_write_q, imem_write_d;
  logic [ADDR_W-1:0]             adr_q, adr_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic                          frame_error_q, frame_error_d;
  logic [WC_W-1:0]               word_count_q, word_count_d;
  logic                          core_hold_q, core_hold_d;
  logic                          io_b_oe_q, io_b_oe_d;

  logic                          sclk_s;
  logic                          sclk_rise_c;
  logic [1:0]                    mode_s;
  state_e                        mode_state_c;
  logic                          in_load_c;
  logic                          load_entry_c;
  logic                          header_ok_c;

  assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
  assign mode_s       = mode_sync_q[SYNC_STAGES-1];
  assign sclk_rise_c  = sclk_s & ~sclk_prev_q;
  assign header_ok_c  = (frame_q >> FRAME_W) == SHIFT_W'(0);

  // Mode pins map straight onto the target state; reserved code holds the core.
  always_comb begin
    mode_state_c = ST_HALT;
    case (mode_s)
      2'b00:   mode_state_c = ST_RUN;
      2'b01:   mode_state_c = ST_LOAD;
      default: mode_state_c = ST_HALT;
    endcase
  end

  assign in_load_c    = (state_q == ST_LOAD) && (mode_state_c == ST_LOAD);
  assign load_entry_c = (state_q != ST_LOAD) && (mode_state_c == ST_LOAD);

  always_comb begin
    state_d       = state_q;
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mode_sync_d   = {mode_sync_q[SYNC_STAGES-2:0], modesel};
    sclk_prev_d   = sclk_s;
    byte_cnt_d    = byte_cnt_q;
    frame_d       = frame_q;
    done_d        = 1'b0;
    wr_pend_d     = 1'b0;
    imem_write_d  = wr_pend_q;
    adr_d         = adr_q;
    data_d        = data_q;
    frame_error_d = frame_error_q;
    word_count_d  = word_count_q;
    core_hold_d   = core_hold_q;
    io_b_oe_d     = io_b_oe_q;

    state_d = mode_state_c;

    // Any cycle not steadily in LOAD drops a partial frame (and a colliding byte).
    if (!in_load_c) begin
      byte_cnt_d = '0;
    end else if (sclk_rise_c) begin
      frame_d = (byte_cnt_q == '0) ? SHIFT_W'(byte_in)
                                   : {frame_q[SHIFT_W-9:0], byte_in};
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d = '0;
        done_d     = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end

    // A completed frame finishes its write even if the mode moves on meanwhile.
    if (done_q) begin
      if (header_ok_c) begin
        adr_d     = frame_q[FRAME_W-1:DATA_W];
        data_d    = frame_q[DATA_W-1:0];
        wr_pend_d = 1'b1;
      end else begin
        frame_error_d = 1'b1;
      end
    end

    if (wr_pend_q && (word_count_q != WC_MAX)) begin
      word_count_d = word_count_q + WC_W'(1);
    end

    if (load_entry_c) begin
      word_count_d  = '0;
      frame_error_d = 1'b0;
    end

    core_hold_d = (state_d != ST_RUN);
    io_b_oe_d   = (state_d == ST_RUN);
  end

  // Mode chain resets to the HALT code so the core stays held while it refills.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HALT;
      sclk_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      mode_sync_q   <= {SYNC_STAGES{2'b10}};
      byte_cnt_q    <= '0;
      frame_q       <= '0;
      done_q        <= 1'b0;
      wr_pend_q     <= 1'b0;
      imem_write_q  <= 1'b0;
      adr_q         <= '0;
      data_q        <= '0;
      frame_error_q <= 1'b0;
      word_count_q  <= '0;
      core_hold_q   <= 1'b1;
      io_b_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      mode_sync_q   <= mode_sync_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_q       <= frame_d;
      done_q        <= done_d;
      wr_pend_q     <= wr_pend_d;
      imem_write_q  <= imem_write_d;
      adr_q         <= adr_d;
      data_q        <= data_d;
      frame_error_q <= frame_error_d;
      word_count_q  <= word_count_d;
      core_hold_q   <= core_hold_d;
      io_b_oe_q     <= io_b_oe_d;
    end
  end

  assign imem.imem_write_adr = adr_q;
  assign imem.imem_in        = data_q;
  assign imem.imem_write     = imem_write_q;

  // Port A is only ever an input and port B input is unused in every state.
  assign core_hold          = core_hold_q;
  assign io_a_input_enable  = 1'b1;
  assign io_a_output_enable = 1'b0;
  assign io_b_input_enable  = 1'b0;
  assign io_b_output_enable = io_b_oe_q;
  assign frame_error        = frame_error_q;
  assign word_count         = word_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomised scoreboard bench for imem_load_ctrl: a byte/frame-level model predicts
// writes, and a monitor checks every strobe's address, data, width and latency.
module tb_imem_load_ctrl;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 40;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int          NB      = 7;
  localparam int          WC_SAT  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic [1:0]        modesel;
  logic [7:0]        byte_in;
  logic              core_hold, ia_ie, ia_oe, ib_ie, ib_oe, frame_error;
  logic [ADDR_W:0]   word_count;

  imem_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk                (clk),
    .reset              (reset),
    .sclk               (sclk),
    .modesel            (modesel),
    .byte_in            (byte_in),
    .imem               (bus),
    .core_hold          (core_hold),
    .io_a_input_enable  (ia_ie),
    .io_a_output_enable (ia_oe),
    .io_b_input_enable  (ib_ie),
    .io_b_output_enable (ib_oe),
    .frame_error        (frame_error),
    .word_count         (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  bytes_q[$];
  logic [1:0]  cur_mode;
  int          exp_wc;
  logic        exp_fe;
  int          last_rise_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  logic        prev_w = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: frames are simply the last 7 bytes accepted while in LOAD.
  task automatic model_byte(input logic [7:0] b);
    logic [55:0] f;
    wr_t e;
    if (cur_mode != 2'b01) return;
    bytes_q.push_back(b);
    if (bytes_q.size() == NB) begin
      f = '0;
      foreach (bytes_q[i]) f = (f << 8) | 56'(bytes_q[i]);
      bytes_q.delete();
      if ((f >> FRAME_W) == 56'd0) begin
        e.adr  = f[FRAME_W-1:DATA_W];
        e.data = f[DATA_W-1:0];
        exp_q.push_back(e);
        if (exp_wc < WC_SAT) exp_wc = exp_wc + 1;
      end else begin
        exp_fe = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int low);
    @(negedge clk);
    byte_in = b;
    sclk = 1'b1;
    last_rise_cyc = cyc;
    model_byte(b);
    repeat (SYNC + 3) @(negedge clk);
    sclk = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic send_frame(input logic [55:0] f, input int low);
    for (int i = 0; i < NB; i++) send_byte(f[55-8*i -: 8], low);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    if (m == 2'b01 && cur_mode != 2'b01) begin
      exp_wc = 0;
      exp_fe = 1'b0;
    end
    if (m != cur_mode) bytes_q.delete();
    cur_mode = m;
    modesel = m;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  function automatic logic [55:0] rnd_frame(input logic bad);
    logic [63:0] r;
    logic [5:0]  h;
    r = {$urandom(), $urandom()};
    h = bad ? 6'($urandom_range(1, 63)) : 6'd0;
    return {h, r[49:0]};
  endfunction

  task automatic check_static(input string tag);
    chk({tag, ".core_hold"}, 64'(core_hold), 64'(cur_mode != 2'b00));
    chk({tag, ".a_ie"},      64'(ia_ie), 64'd1);
    chk({tag, ".a_oe"},      64'(ia_oe), 64'd0);
    chk({tag, ".b_ie"},      64'(ib_ie), 64'd0);
    chk({tag, ".b_oe"},      64'(ib_oe), 64'(cur_mode == 2'b00));
    chk({tag, ".frame_err"}, 64'(frame_error), 64'(exp_fe));
    chk({tag, ".word_count"}, 64'(word_count), 64'(exp_wc));
  endtask

  // Monitor: every strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.imem_write === 1'b1) begin
      wr_t e;
      n_strobe = n_strobe + 1;
      chk("strobe_width", 64'(prev_w), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_strobe: got adr 0x%0h expected no write", bus.imem_write_adr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr",  64'(bus.imem_write_adr), 64'(e.adr));
        chk("wr_data", 64'(bus.imem_in),        64'(e.data));
        chk("strobe_latency", 64'(cyc - last_rise_cyc), 64'(SYNC + 3));
      end
    end
    prev_w = bus.imem_write;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset = 1'b0;
    sclk = 1'b0;
    byte_in = 8'h00;
    modesel = 2'b10;
    cur_mode = 2'b10;
    exp_wc = 0;
    exp_fe = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.imem_write", 64'(bus.imem_write), 64'd0);
    chk("rst.adr", 64'(bus.imem_write_adr), 64'd0);
    chk("rst.data", 64'(bus.imem_in), 64'd0);
    check_static("rst");

    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_static("halt");
    for (int i = 0; i < 8; i++) send_byte(8'($urandom()), 2);
    check_static("halt_bytes");

    // Basic frame with latency checked by the monitor.
    set_mode(2'b01);
    check_static("load_entry");
    send_frame(56'h002A1122334455, 2);
    repeat (4) @(negedge clk);
    chk("t2.strobes", 64'(n_strobe), 64'd1);
    chk("t2.adr_hold", 64'(bus.imem_write_adr), 64'h02A);
    chk("t2.data_hold", 64'(bus.imem_in), 64'h1122334455);
    chk("t2.word_count", 64'(word_count), 64'd1);
    check_static("t2");

    // Bad header is sticky until LOAD is re-entered.
    send_frame(56'h04000000000000, 2);
    repeat (4) @(negedge clk);
    check_static("bad_hdr");
    send_frame(rnd_frame(1'b0), 2);
    repeat (4) @(negedge clk);
    chk("t3.fe_sticky", 64'(frame_error), 64'd1);
    check_static("after_good");
    set_mode(2'b10);
    set_mode(2'b01);
    chk("t3.fe_cleared", 64'(frame_error), 64'd0);
    check_static("reenter");

    // Partial frame abandoned by a mode change.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 2);
    set_mode(2'b00);
    check_static("run");
    set_mode(2'b01);
    s0 = n_strobe;
    send_frame(56'h00015A5A5AA5A5, 2);
    repeat (4) @(negedge clk);
    chk("t4.strobes", 64'(n_strobe - s0), 64'd1);
    chk("t4.adr", 64'(bus.imem_write_adr), 64'h001);
    check_static("t4");

    // Random mix of good, bad, aborted frames and idle-mode traffic.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: send_frame(rnd_frame(1'b0), int'($urandom_range(2, 4)));
        1: send_frame(rnd_frame(1'b1), int'($urandom_range(2, 4)));
        2: begin
          for (int i = 0; i < int'($urandom_range(1, 6)); i++) send_byte(8'($urandom()), 2);
          set_mode($urandom_range(0, 1) == 0 ? 2'b00 : 2'b11);
          for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 2);
          set_mode(2'b01);
        end
        default: begin
          set_mode(2'b10);
          set_mode(2'b01);
        end
      endcase
    end
    repeat (4) @(negedge clk);
    check_static("random");

    // Fill every address then one more: count saturates.
    set_mode(2'b10);
    set_mode(2'b01);
    s0 = n_strobe;
    for (int a = 0; a <= WC_SAT; a++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      send_frame({6'd0, 10'(a % WC_SAT), r[39:0]}, 2);
    end
    repeat (4) @(negedge clk);
    chk("t5.strobes", 64'(n_strobe - s0), 64'(WC_SAT + 1));
    chk("t5.wc_sat", 64'(word_count), 64'(WC_SAT));
    check_static("t5");

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom()), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst.core_hold", 64'(core_hold), 64'd1);
    chk("arst.write", 64'(bus.imem_write), 64'd0);
    chk("arst.adr", 64'(bus.imem_write_adr), 64'd0);
    chk("arst.data", 64'(bus.imem_in), 64'd0);
    chk("arst.wc", 64'(word_count), 64'd0);
    chk("arst.b_oe", 64'(ib_oe), 64'd0);
    bytes_q.delete();
    exp_wc = 0;
    exp_fe = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    s0 = n_strobe;
    send_frame(56'h0003DEADBEEF01, 2);
    repeat (4) @(negedge clk);
    chk("t6.strobes", 64'(n_strobe - s0), 64'd1);
    chk("t6.data", 64'(bus.imem_in), 64'hDEADBEEF01);
    check_static("t6");

    repeat (20) @(negedge clk);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
